// File: rtl/uart_resp_pkg.sv
// Shared constants, FSM state type and CRC helper for the UART response transmitter.
package uart_resp_pkg;

  // Fixed frame bytes and frame length
  localparam logic [7:0] RESP_HDR = 8'h55;
  localparam logic [7:0] RESP_FTR = 8'hAA;
  localparam int         RESP_LEN = 6;

  // Result codes carried in the status byte
  localparam logic [7:0] STATUS_OK      = 8'h00;
  localparam logic [7:0] STATUS_CRC_ERR = 8'h01;

  // CRC-8 generator polynomial x^8 + x^2 + x + 1, no reflection, no final XOR
  localparam logic [7:0] CRC8_POLY = 8'h07;

  // Frame positions of the variable bytes
  localparam logic [2:0] IDX_HDR    = 3'd0;
  localparam logic [2:0] IDX_FUNC   = 3'd1;
  localparam logic [2:0] IDX_CH     = 3'd2;
  localparam logic [2:0] IDX_STATUS = 3'd3;
  localparam logic [2:0] IDX_CRC    = 3'd4;
  localparam logic [2:0] IDX_FTR    = 3'd5;

  // Top-level sequencer states
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } resp_state_e;

  // Fold one byte into a running CRC-8, MSB first
  function automatic logic [7:0] crc8_update(input logic [7:0] crc_in, input logic [7:0] data);
    logic [7:0] crc;
    crc = crc_in ^ data;
    for (int i = 0; i < 8; i++) begin
      if (crc[7]) begin
        crc = {crc[6:0], 1'b0} ^ CRC8_POLY;
      end else begin
        crc = {crc[6:0], 1'b0};
      end
    end
    return crc;
  endfunction

  // CRC-8 over func, ch, status in that order, starting from zero
  function automatic logic [7:0] crc8(input logic [7:0] func, input logic [7:0] ch,
                                      input logic [7:0] status);
    logic [7:0] crc;
    crc = 8'h00;
    crc = crc8_update(crc, func);
    crc = crc8_update(crc, ch);
    crc = crc8_update(crc, status);
    return crc;
  endfunction

endpackage

// File: rtl/uart_resp_tx_byte.sv
// Serializes one byte as start bit, 8 data bits LSB first, stop bit.
// tx_done marks the final cycle of the stop bit; a tx_start seen in that
// cycle loads the next byte on the same edge so bytes run with no gap.
module uart_tx_byte #(
  parameter int CLK_FREQ = 50000000,
  parameter int UART_BPS = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       txd
);

  localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
  localparam int CNT_W        = (BAUD_CNT_MAX > 1) ? $clog2(BAUD_CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_CNT_MAX - 1);
  localparam logic [3:0]       BIT_LAST = 4'd9;

  logic             busy_q,  busy_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [3:0]       bit_q,   bit_d;
  logic [9:0]       shift_q, shift_d;
  logic             txd_q,   txd_d;

  logic bit_end;
  logic byte_end;
  logic load;

  assign bit_end  = busy_q && (cnt_q == CNT_LAST);
  assign byte_end = bit_end && (bit_q == BIT_LAST);
  assign load     = tx_start && (!busy_q || byte_end);

  assign tx_busy = busy_q;
  assign tx_done = byte_end;
  assign txd     = txd_q;

  // Baud counting, bit stepping and line level for the next cycle
  always_comb begin
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    if (load) begin
      busy_d  = 1'b1;
      cnt_d   = '0;
      bit_d   = 4'd0;
      shift_d = {1'b1, tx_data, 1'b0};
      txd_d   = 1'b0;
    end else if (byte_end) begin
      busy_d  = 1'b0;
      cnt_d   = '0;
      bit_d   = 4'd0;
      shift_d = '1;
      txd_d   = 1'b1;
    end else if (bit_end) begin
      cnt_d   = '0;
      bit_d   = bit_q + 4'd1;
      shift_d = {1'b1, shift_q[9:1]};
      txd_d   = shift_q[1];
    end else if (busy_q) begin
      cnt_d   = cnt_q + 1'b1;
    end
  end

  // Serializer state; the line idles high through reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      bit_q   <= 4'd0;
      shift_q <= '1;
      txd_q   <= 1'b1;
    end else begin
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
    end
  end

endmodule

// File: rtl/uart_resp_tx.sv
// Sends a 6-byte response frame (0x55, func, ch, status, crc, 0xAA) over UART
// for each accepted request. Request fields and their CRC are latched at the
// acceptance edge so the frame in flight never sees later input changes.
module uart_resp_tx #(
  parameter int CLK_FREQ = 50000000,
  parameter int UART_BPS = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_func,
  input  logic [7:0] req_ch,
  input  logic [7:0] req_status,
  output logic       uart_txd,
  output logic       busy,
  output logic       frame_done
);

  import uart_resp_pkg::*;

  localparam logic [2:0] LAST_IDX = 3'(RESP_LEN - 1);

  resp_state_e state_q, state_d;
  logic [7:0]  func_q,   func_d;
  logic [7:0]  ch_q,     ch_d;
  logic [7:0]  status_q, status_d;
  logic [7:0]  crc_q,    crc_d;
  logic [2:0]  byte_idx_q, byte_idx_d;
  logic        start_q,  start_d;
  logic        frame_done_q, frame_done_d;
  logic        ready_en_q, ready_en_d;

  logic       accept;
  logic       tx_start;
  logic [2:0] tx_sel;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       tx_done;

  assign req_ready  = ready_en_q && (state_q == ST_IDLE) && !tx_busy;
  assign accept     = req_valid && req_ready;
  assign busy       = (state_q == ST_SEND);
  assign frame_done = frame_done_q;

  // Sequencer: accept a request, then feed bytes 0..5 back to back
  always_comb begin
    state_d      = state_q;
    func_d       = func_q;
    ch_d         = ch_q;
    status_d     = status_q;
    crc_d        = crc_q;
    byte_idx_d   = byte_idx_q;
    start_d      = 1'b0;
    frame_done_d = 1'b0;
    ready_en_d   = 1'b1;
    tx_start     = 1'b0;
    tx_sel       = byte_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d    = ST_SEND;
          func_d     = req_func;
          ch_d       = req_ch;
          status_d   = req_status;
          crc_d      = crc8(req_func, req_ch, req_status);
          byte_idx_d = IDX_HDR;
          start_d    = 1'b1;
        end
      end
      ST_SEND: begin
        if (start_q) begin
          tx_start = 1'b1;
          tx_sel   = IDX_HDR;
        end else if (tx_done) begin
          if (byte_idx_q == LAST_IDX) begin
            state_d      = ST_IDLE;
            frame_done_d = 1'b1;
          end else begin
            tx_start   = 1'b1;
            tx_sel     = byte_idx_q + 3'd1;
            byte_idx_d = byte_idx_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pick the frame byte for the requested position
  always_comb begin
    tx_data = RESP_FTR;
    case (tx_sel)
      IDX_HDR:    tx_data = RESP_HDR;
      IDX_FUNC:   tx_data = func_q;
      IDX_CH:     tx_data = ch_q;
      IDX_STATUS: tx_data = status_q;
      IDX_CRC:    tx_data = crc_q;
      IDX_FTR:    tx_data = RESP_FTR;
      default:    tx_data = RESP_FTR;
    endcase
  end

  // Sequencer registers; reset aborts any frame and holds ready low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      func_q       <= 8'h00;
      ch_q         <= 8'h00;
      status_q     <= 8'h00;
      crc_q        <= 8'h00;
      byte_idx_q   <= 3'd0;
      start_q      <= 1'b0;
      frame_done_q <= 1'b0;
      ready_en_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      func_q       <= func_d;
      ch_q         <= ch_d;
      status_q     <= status_d;
      crc_q        <= crc_d;
      byte_idx_q   <= byte_idx_d;
      start_q      <= start_d;
      frame_done_q <= frame_done_d;
      ready_en_q   <= ready_en_d;
    end
  end

  uart_tx_byte #(
    .CLK_FREQ (CLK_FREQ),
    .UART_BPS (UART_BPS)
  ) u_tx_byte (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done),
    .txd      (uart_txd)
  );

endmodule

// File: tb/tb_uart_resp_tx.sv
// Bench for uart_resp_tx: a mid-bit-sampling receiver rebuilds each frame and
// compares it with frames queued when requests are accepted. The bit rate is
// raised so each bit is 10 clocks, keeping the run short; every timing
// expectation below is derived from BAUD.
module tb_uart_resp_tx;

  localparam int CLK_FREQ  = 50_000_000;
  localparam int UART_BPS  = 5_000_000;
  localparam int BAUD      = CLK_FREQ / UART_BPS;
  localparam int FRAME_CYC = 60 * BAUD;
  localparam int TIMEOUT   = 4 * FRAME_CYC;

  typedef logic [47:0] frame_t;

  typedef struct {
    logic [7:0] func;
    logic [7:0] ch;
    logic [7:0] status;
    logic [7:0] crc;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic [7:0] req_func = 8'h00;
  logic [7:0] req_ch = 8'h00;
  logic [7:0] req_status = 8'h00;
  logic       req_ready;
  logic       uart_txd;
  logic       busy;
  logic       frame_done;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;

  frame_t exp_q[$];
  int     frame_starts[$];

  logic   rx_active = 1'b0;
  int     rx_cnt = 0;
  int     rx_bit = 0;
  int     rx_nbytes = 0;
  logic [7:0] rx_shift = 8'h00;
  frame_t rx_frame = '0;
  int     frame_start = 0;
  int     edge_err = 0;
  logic   txd_prev = 1'b1;
  int     frames_rx = 0;
  int     fd_count = 0;
  logic   fd_prev = 1'b0;

  uart_resp_tx #(
    .CLK_FREQ (CLK_FREQ),
    .UART_BPS (UART_BPS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_func   (req_func),
    .req_ch     (req_ch),
    .req_status (req_status),
    .uart_txd   (uart_txd),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Bit-serial CRC-8, poly 0x07, init 0
  function automatic logic [7:0] crc8_model(input logic [7:0] a, input logic [7:0] b,
                                            input logic [7:0] c);
    logic [23:0] msg;
    logic [7:0]  r;
    logic        fb;
    msg = {a, b, c};
    r = 8'h00;
    for (int i = 23; i >= 0; i--) begin
      fb = r[7] ^ msg[i];
      r = {r[6:0], 1'b0};
      if (fb) r = r ^ 8'h07;
    end
    return r;
  endfunction

  function automatic frame_t make_frame(input logic [7:0] f, input logic [7:0] c,
                                        input logic [7:0] s, input logic [7:0] crc);
    return {8'hAA, crc, s, c, f, 8'h55};
  endfunction

  // Receiver: sample every bit at its middle, check that every edge is on the bit grid
  always @(negedge clk) begin
    if (!rst_n) begin
      rx_active = 1'b0;
      rx_nbytes = 0;
      edge_err = 0;
      txd_prev = 1'b1;
    end else begin
      if (uart_txd !== txd_prev && (rx_active || rx_nbytes > 0)) begin
        if ((cyc - frame_start) % BAUD != 0) edge_err++;
      end
      if (!rx_active) begin
        if (uart_txd == 1'b0) begin
          rx_active = 1'b1;
          rx_cnt = 0;
          rx_bit = 0;
          if (rx_nbytes == 0) begin
            frame_start = cyc;
            frame_starts.push_back(cyc);
            edge_err = 0;
          end
        end
      end else begin
        rx_cnt++;
        if (rx_cnt == rx_bit * BAUD + BAUD / 2) begin
          if (rx_bit == 0) begin
            if (uart_txd !== 1'b0) edge_err++;
          end else if (rx_bit <= 8) begin
            rx_shift = {uart_txd, rx_shift[7:1]};
          end else begin
            if (uart_txd !== 1'b1) edge_err++;
            rx_frame[8*rx_nbytes +: 8] = rx_shift;
            rx_nbytes++;
            rx_active = 1'b0;
            if (rx_nbytes == 6) begin
              frames_rx++;
              rx_nbytes = 0;
              if (exp_q.size() == 0) begin
                check_output("unexpected_frame", rx_frame, '0);
              end else begin
                check_output("frame_bytes", rx_frame, exp_q.pop_front());
              end
              check_output("bit_edges", 48'(edge_err), 48'd0);
            end
          end
          rx_bit++;
        end
      end
      txd_prev = uart_txd;
    end
  end

  // frame_done: single cycle, a full frame after the start edge, with ready up
  always @(negedge clk) begin
    if (rst_n && frame_done) begin
      fd_count++;
      check_output("frame_done_time", 48'(cyc - frame_start), 48'(FRAME_CYC));
      check_output("ready_at_done", req_ready, 1);
      check_output("busy_at_done", busy, 0);
      check_output("frame_done_width", fd_prev, 0);
    end
    fd_prev = frame_done;
  end

  // Drive one request, wait for acceptance, queue its frame, check start timing
  task automatic apply_stimulus(input logic [7:0] f, input logic [7:0] c,
                                input logic [7:0] s, input logic [7:0] crc);
    int waited;
    waited = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_func = f;
    req_ch = c;
    req_status = s;
    while (!req_ready && waited < TIMEOUT) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      check_output("accept_timeout", req_ready, 1);
      req_valid = 1'b0;
      return;
    end
    exp_q.push_back(make_frame(f, c, s, crc));
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check_output("busy_after_accept", busy, 1);
    check_output("txd_high_at_accept", uart_txd, 1);
    @(posedge clk);
    #1;
    check_output("txd_low_next_edge", uart_txd, 0);
  endtask

  task automatic wait_frames();
    int waited;
    waited = 0;
    while ((exp_q.size() != 0 || busy) && waited < 4 * TIMEOUT) begin
      @(negedge clk);
      waited++;
    end
    check_output("frames_drained", 48'(exp_q.size()), 48'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t tbl[6];
    vec_t held[3];
    int   idle_cnt;
    int   waited;
    int   n0;
    int   fr0;
    int   fd0;
    int   target;
    int   bad;

    tbl[0] = '{8'h02, 8'h01, 8'h01, 8'hC4};
    tbl[1] = '{8'h01, 8'h00, 8'h00, 8'h6B};
    tbl[2] = '{8'h00, 8'h00, 8'h00, 8'h00};
    tbl[3] = '{8'hFF, 8'hFF, 8'hFF, crc8_model(8'hFF, 8'hFF, 8'hFF)};
    tbl[4] = '{8'hA5, 8'h3C, 8'h00, crc8_model(8'hA5, 8'h3C, 8'h00)};
    tbl[5] = '{8'h10, 8'h20, 8'h02, crc8_model(8'h10, 8'h20, 8'h02)};

    held[0] = '{8'h11, 8'h22, 8'h00, crc8_model(8'h11, 8'h22, 8'h00)};
    held[1] = '{8'h33, 8'h44, 8'h01, crc8_model(8'h33, 8'h44, 8'h01)};
    held[2] = '{8'h55, 8'h66, 8'h00, crc8_model(8'h55, 8'h66, 8'h00)};

    // Reset values, then ready one edge after release
    repeat (3) @(negedge clk);
    check_output("reset_txd", uart_txd, 1);
    check_output("reset_ready", req_ready, 0);
    check_output("reset_busy", busy, 0);
    check_output("reset_frame_done", frame_done, 0);
    rst_n = 1'b1;
    #1;
    check_output("ready_before_edge", req_ready, 0);
    @(negedge clk);
    check_output("ready_after_edge", req_ready, 1);

    // Table-driven frames
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(tbl[i].func, tbl[i].ch, tbl[i].status, tbl[i].crc);
      wait_frames();
    end

    // Request pulses while busy are ignored, no second frame afterwards
    fr0 = frames_rx;
    apply_stimulus(8'h3A, 8'h4B, 8'h01, crc8_model(8'h3A, 8'h4B, 8'h01));
    repeat (10 * BAUD) @(negedge clk);
    req_valid = 1'b1;
    req_func = 8'hEE;
    req_ch = 8'hDD;
    req_status = 8'hCC;
    repeat (5) @(negedge clk);
    req_valid = 1'b0;
    wait_frames();
    bad = 0;
    repeat (2 * 10 * BAUD) begin
      @(negedge clk);
      if (busy || !uart_txd) bad++;
    end
    check_output("no_second_frame", 48'(bad), 48'd0);
    check_output("busy_test_frames", 48'(frames_rx - fr0), 48'd1);

    // Held valid with changing fields: one idle cycle between busy windows
    n0 = frame_starts.size();
    @(negedge clk);
    req_valid = 1'b1;
    req_func = held[0].func;
    req_ch = held[0].ch;
    req_status = held[0].status;
    for (int k = 0; k < 3; k++) begin
      idle_cnt = 0;
      waited = 0;
      while (waited < TIMEOUT) begin
        if (!busy) idle_cnt++;
        if (req_ready) break;
        @(negedge clk);
        waited++;
      end
      if (!req_ready) begin
        check_output("held_accept_timeout", req_ready, 1);
        break;
      end
      if (k > 0) check_output("idle_gap_cycles", 48'(idle_cnt), 48'd1);
      exp_q.push_back(make_frame(held[k].func, held[k].ch, held[k].status, held[k].crc));
      @(posedge clk);
      #1;
      if (k < 2) begin
        req_func = held[k+1].func;
        req_ch = held[k+1].ch;
        req_status = held[k+1].status;
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clk);
    end
    wait_frames();
    if (frame_starts.size() >= n0 + 3) begin
      check_output("b2b_spacing_1", 48'(frame_starts[n0+1] - frame_starts[n0]), 48'(FRAME_CYC + 2));
      check_output("b2b_spacing_2", 48'(frame_starts[n0+2] - frame_starts[n0+1]), 48'(FRAME_CYC + 2));
    end else begin
      check_output("b2b_frame_count", 48'(frame_starts.size() - n0), 48'd3);
    end

    // Reset during byte 2, data bit 3 (line low), aborts with no frame_done
    apply_stimulus(8'h5A, 8'h81, 8'h01, crc8_model(8'h5A, 8'h81, 8'h01));
    target = frame_start + 2 * 10 * BAUD + 4 * BAUD + BAUD / 2;
    waited = 0;
    while (cyc < target && waited < TIMEOUT) begin
      @(negedge clk);
      waited++;
    end
    check_output("txd_low_before_reset", uart_txd, 0);
    fd0 = fd_count;
    #2;
    rst_n = 1'b0;
    #1;
    check_output("abort_txd", uart_txd, 1);
    check_output("abort_busy", busy, 0);
    check_output("abort_ready", req_ready, 0);
    check_output("abort_frame_done", frame_done, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (2 * 10 * BAUD) begin
      @(negedge clk);
      if (busy || !uart_txd) bad++;
    end
    check_output("no_resume_after_reset", 48'(bad), 48'd0);
    check_output("no_frame_done_on_abort", 48'(fd_count - fd0), 48'd0);

    // Clean frame after reset
    fr0 = frames_rx;
    apply_stimulus(8'h02, 8'h01, 8'h01, 8'hC4);
    wait_frames();
    check_output("post_reset_frames", 48'(frames_rx - fr0), 48'd1);

    repeat (5) @(negedge clk);
    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_resp_tx.md
UART_RESP_TX -- requirements
Module: uart_resp_tx

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 Parameter UART_BPS, default 115200, serial bit rate; BAUD_CNT_MAX = CLK_FREQ/UART_BPS (434 at defaults).
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  1  response request; held until accepted.
REQ-006 req_ready  output  1  high only in IDLE; accept = req_valid & req_ready on a rising edge.
REQ-007 req_func  input  8  echoed reg_func byte.
REQ-008 req_ch  input  8  echoed channel byte.
REQ-009 req_status  input  8  result code (0x00 OK, 0x01 CRC error, others reserved).
REQ-010 uart_txd  output  1  serial output, idle high, registered.
REQ-011 busy  output  1  high from the edge after acceptance until frame end.
REQ-012 frame_done  output  1  one-cycle pulse at frame end.

Function
REQ-013 The block SHALL capture req_func/req_ch/req_status into registers on acceptance; later input changes SHALL not affect the frame in flight.
REQ-014 The frame SHALL be 6 bytes in order: 0x55, func, ch, status, crc, 0xAA.
REQ-015 crc SHALL be CRC-8: poly 0x07, init 0x00, no reflection, no final XOR, over func, ch, status in that order.
REQ-016 Each byte SHALL be sent as: start bit 0, 8 data bits LSB first, stop bit 1.
REQ-017 Each bit SHALL last exactly BAUD_CNT_MAX clocks.
REQ-018 No idle gap SHALL occur between bytes; a frame is 60*BAUD_CNT_MAX clocks.
REQ-019 uart_txd SHALL go low on the first rising edge after the acceptance edge.
REQ-020 Top FSM states: IDLE -> SEND on accept; SEND -> IDLE when the stop bit of byte 5 completes.
REQ-021 Byte index SHALL be 0..5, with no wrap.
REQ-022 Bit index SHALL be 0..9, advancing when the baud counter reaches BAUD_CNT_MAX-1.
REQ-023 frame_done SHALL pulse for the single cycle in which the FSM returns to IDLE.
REQ-024 req_ready SHALL rise in that same cycle.
REQ-025 A request held across frame_done SHALL be accepted no earlier than the next edge.
REQ-026 req_valid while busy SHALL be ignored, with no queuing and no corruption of the frame in flight.
REQ-027 Back-to-back requests SHALL be separated by exactly one idle-high cycle.

Reset
REQ-028 While rst_n is low, outputs SHALL be: uart_txd=1, req_ready=0, busy=0, frame_done=0.
REQ-029 While rst_n is low, the FSM SHALL be in IDLE with all counters and registers cleared.
REQ-030 req_ready SHALL assert on the first edge after rst_n deasserts.
REQ-031 Reset mid-frame SHALL abort immediately: uart_txd=1 asynchronously, no frame_done, no resumption after release.

Structure
REQ-032 Package uart_resp_pkg SHALL hold: RESP_HDR=8'h55, RESP_FTR=8'hAA, RESP_LEN=6, status code constants, the FSM state typedef, and the crc8 function.
REQ-033 Sub-module uart_tx_byte SHALL serialize one byte.
REQ-034 uart_tx_byte ports: clk, rst_n, tx_start, tx_data[7:0], tx_busy, tx_done, txd.
REQ-035 uart_tx_byte SHALL take the same CLK_FREQ/UART_BPS parameters.
REQ-036 uart_resp_tx SHALL sequence bytes into uart_tx_byte.

Verification
REQ-037 Bench decodes uart_txd with a mid-bit-sampling UART receiver at 115200 (50 MHz clk) and collects 6 bytes per frame.
REQ-038 req func=0x02, ch=0x01, status=0x01 -> bytes 55 02 01 01 C4 AA; frame_done 26040 clocks after the first txd fall.
REQ-039 req 0x01,0x00,0x00 -> 55 01 00 00 6B AA; req 0x00,0x00,0x00 -> crc 0x00.
REQ-040 Bit timing: every txd edge lands on a multiple of 434 clocks from the start edge, ±0 cycles.
REQ-041 req_valid held high continuously with changing fields -> frames separated by exactly one idle cycle, each frame carrying the fields present at its acceptance edge.
REQ-042 req_valid pulsed during busy -> ignored; output frame unchanged, and no second frame if valid has dropped before frame_done.
REQ-043 rst_n asserted at byte 2 bit 4 -> txd=1 within the same cycle, no frame_done.
REQ-044 After rst_n release and a new request -> a clean full frame.
